spi_apb_master: RTL and testbench

APB initiator that turns a simple valid/ready command port into APB3 transfers toward the SPI register slave and other peripherals on the same bus. It sits between a local controller (boot sequencer, DMA stub or testbench driver) and the APB fabric. It handles one outstanding transfer at a time, with a bounded-wait timeout. Every transfer produces exactly one response: read data, slave error, or timeout.

---
 rtl/spi_apb_pkg.sv | 25 ++
 rtl/spi_apb_wait_timer.sv | 30 +++
 rtl/spi_apb_master.sv | 148 ++++++++++++++
 tb/tb_spi_apb_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_apb_pkg.sv
// Shared constants for the APB initiator: one-hot state encoding and the SPI slave register map.
package spi_apb_pkg;

  localparam int STATE_IDLE   = 0;
  localparam int STATE_SETUP  = 1;
  localparam int STATE_ACCESS = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_SETUP  = 3'b010,
    S_ACCESS = 3'b100
  } state_t;

  localparam logic [31:0] SPI_BASE = 32'ha0300000;
  localparam logic [31:0] SPI_CR1  = 32'd0;
  localparam logic [31:0] SPI_CR2  = 32'd4;
  localparam logic [31:0] SPI_SPR  = 32'd8;
  localparam logic [31:0] SPI_SR   = 32'd12;
  localparam logic [31:0] SPI_DR   = 32'd16;

  function automatic logic [31:0] spi_reg_addr(input logic [31:0] offset);
    return SPI_BASE + offset;
  endfunction

endpackage

// File: rtl/spi_apb_wait_timer.sv
// Counts ACCESS wait cycles; expired flags the last allowed wait cycle. Saturating, never wraps.
module spi_apb_wait_timer #(
  parameter int TIMEOUT_CYCLE = 6
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_cnt_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLE > 0) ? $clog2(TIMEOUT_CYCLE + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLE);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLE > 0) ? CW'(TIMEOUT_CYCLE - 1) : '0;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_cnt_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT_CYCLE != 0) && (r_cnt == CNT_LAST);

endmodule

// File: rtl/spi_apb_master.sv
// APB3 initiator: one command at a time, 3 cycles minimum plus slave wait states, bounded by a timeout.
// cmd_ready_out is high only in IDLE; exactly one registered response pulse per accepted command.
module spi_apb_master
  import spi_apb_pkg::*;
#(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLE  = 6
) (
  input  logic                        apb_clk_in,
  input  logic                        apb_rst_in,
  input  logic                        cmd_valid_in,
  output logic                        cmd_ready_out,
  input  logic                        cmd_write_in,
  input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr_in,
  input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata_in,
  input  logic [APB_DATA_WIDTH/8-1:0] cmd_strb_in,
  output logic                        rsp_valid_out,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_out,
  output logic                        rsp_err_out,
  output logic                        rsp_timeout_out,
  output logic [APB_ADDR_WIDTH-1:0]   apb_addr_out,
  output logic                        apb_psel_out,
  output logic                        apb_penable_out,
  output logic                        apb_write_out,
  output logic [APB_DATA_WIDTH-1:0]   apb_wdata_out,
  output logic [APB_DATA_WIDTH/8-1:0] apb_strb_out,
  input  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in,
  input  logic                        apb_ready_in,
  input  logic                        apb_slverr_in
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_done;
  logic   w_abort;
  logic   w_expired;

  logic                        r_psel;
  logic                        r_penable;
  logic                        r_write;
  logic [APB_ADDR_WIDTH-1:0]   r_addr;
  logic [APB_DATA_WIDTH-1:0]   r_wdata;
  logic [APB_DATA_WIDTH/8-1:0] r_strb;
  logic                        r_rsp_valid;
  logic [APB_DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                        r_rsp_err;
  logic                        r_rsp_timeout;

  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_in) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        // ready takes priority over a timeout landing on the same edge
        if (apb_ready_in) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_expired) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  spi_apb_wait_timer #(
    .TIMEOUT_CYCLE(TIMEOUT_CYCLE)
  ) u_wait_timer (
    .i_clk     (apb_clk_in),
    .i_rst     (apb_rst_in),
    .i_clear   (r_state[STATE_SETUP]),
    .i_cnt_en  (r_state[STATE_ACCESS] & ~apb_ready_in),
    .o_expired (w_expired)
  );

  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) begin
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_strb        <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= w_done | w_abort;
      if (w_accept) begin
        r_psel  <= 1'b1;
        r_write <= cmd_write_in;
        r_addr  <= cmd_addr_in;
        r_wdata <= cmd_write_in ? cmd_wdata_in : '0;
        r_strb  <= cmd_write_in ? cmd_strb_in : '0;
      end
      if (r_state[STATE_SETUP]) begin
        r_penable <= 1'b1;
      end
      if (w_done || w_abort) begin
        r_psel    <= 1'b0;
        r_penable <= 1'b0;
      end
      if (w_done) begin
        r_rsp_err     <= apb_slverr_in;
        r_rsp_timeout <= 1'b0;
        r_rsp_rdata   <= (!r_write && !apb_slverr_in) ? apb_rdata_in : '0;
      end else if (w_abort) begin
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
        r_rsp_rdata   <= '0;
      end
    end
  end

  assign cmd_ready_out   = r_state[STATE_IDLE];
  assign apb_psel_out    = r_psel;
  assign apb_penable_out = r_penable;
  assign apb_write_out   = r_write;
  assign apb_addr_out    = r_addr;
  assign apb_wdata_out   = r_wdata;
  assign apb_strb_out    = r_strb;
  assign rsp_valid_out   = r_rsp_valid;
  assign rsp_rdata_out   = r_rsp_rdata;
  assign rsp_err_out     = r_rsp_err;
  assign rsp_timeout_out = r_rsp_timeout;

endmodule

// File: tb/tb_spi_apb_master.sv
// Self-checking bench for spi_apb_master: directed vector table, reset/back-to-back sequences, random transfers.
module tb_spi_apb_master;
  import spi_apb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid_in;
  logic            cmd_ready_out;
  logic            cmd_write_in;
  logic [AW-1:0]   cmd_addr_in;
  logic [DW-1:0]   cmd_wdata_in;
  logic [DW/8-1:0] cmd_strb_in;
  logic            rsp_valid_out;
  logic [DW-1:0]   rsp_rdata_out;
  logic            rsp_err_out;
  logic            rsp_timeout_out;
  logic [AW-1:0]   apb_addr_out;
  logic            apb_psel_out;
  logic            apb_penable_out;
  logic            apb_write_out;
  logic [DW-1:0]   apb_wdata_out;
  logic [DW/8-1:0] apb_strb_out;
  logic [DW-1:0]   apb_rdata_in;
  logic            apb_ready_in;
  logic            apb_slverr_in;

  always #5 clk = ~clk;

  spi_apb_master #(
    .APB_DATA_WIDTH(DW),
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLE (TO)
  ) dut (
    .apb_clk_in      (clk),
    .apb_rst_in      (rst),
    .cmd_valid_in    (cmd_valid_in),
    .cmd_ready_out   (cmd_ready_out),
    .cmd_write_in    (cmd_write_in),
    .cmd_addr_in     (cmd_addr_in),
    .cmd_wdata_in    (cmd_wdata_in),
    .cmd_strb_in     (cmd_strb_in),
    .rsp_valid_out   (rsp_valid_out),
    .rsp_rdata_out   (rsp_rdata_out),
    .rsp_err_out     (rsp_err_out),
    .rsp_timeout_out (rsp_timeout_out),
    .apb_addr_out    (apb_addr_out),
    .apb_psel_out    (apb_psel_out),
    .apb_penable_out (apb_penable_out),
    .apb_write_out   (apb_write_out),
    .apb_wdata_out   (apb_wdata_out),
    .apb_strb_out    (apb_strb_out),
    .apb_rdata_in    (apb_rdata_in),
    .apb_ready_in    (apb_ready_in),
    .apb_slverr_in   (apb_slverr_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // lat = clock edges from the accepting edge (counted as 1) until rsp_valid is visible
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slverr;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int waits, input logic slverr,
                              input logic [31:0] rdata, input int lat, input logic [31:0] exp_rdata,
                              input logic exp_err, input logic exp_to);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.waits = waits;
    v.slverr = slverr; v.rdata = rdata; v.lat = lat; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err; v.exp_to = exp_to;
    return v;
  endfunction

  // Reference: slave answers after `waits` not-ready samples; more than TO-1 waits means abort
  function automatic vec_t model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input int waits, input logic slverr,
                                 input logic [31:0] rdata);
    vec_t v;
    v = mk(wr, addr, wdata, strb, waits, slverr, rdata, 0, 32'h0, 1'b0, 1'b0);
    v.exp_to    = (waits >= TO);
    v.lat       = 3 + ((waits < TO) ? waits : TO - 1);
    v.exp_err   = v.exp_to || slverr;
    v.exp_rdata = (wr || v.exp_err) ? 32'h0 : rdata;
    return v;
  endfunction

  task automatic run_xfer(input vec_t v);
    int cnt;
    int guard;
    logic [31:0] exp_wd;
    logic [3:0]  exp_sb;
    exp_wd = v.wr ? v.wdata : 32'h0;
    exp_sb = v.wr ? v.strb : 4'h0;
    guard = 0;
    while (!cmd_ready_out && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("cmd_ready_idle", cmd_ready_out, 1);
    cmd_valid_in  = 1'b1;
    cmd_write_in  = v.wr;
    cmd_addr_in   = v.addr;
    cmd_wdata_in  = v.wdata;
    cmd_strb_in   = v.strb;
    apb_rdata_in  = v.rdata;
    apb_slverr_in = v.slverr;
    apb_ready_in  = 1'b0;
    @(posedge clk); #1;
    cnt = 1;
    check("setup_psel", apb_psel_out, 1);
    check("setup_penable", apb_penable_out, 0);
    check("setup_cmd_ready", cmd_ready_out, 0);
    check("setup_addr", apb_addr_out, v.addr);
    check("setup_write", apb_write_out, v.wr);
    check("setup_wdata", apb_wdata_out, exp_wd);
    check("setup_strb", apb_strb_out, exp_sb);
    // junk command held valid while busy must be ignored
    cmd_write_in = ~v.wr;
    cmd_addr_in  = ~v.addr;
    cmd_wdata_in = ~v.wdata;
    cmd_strb_in  = ~v.strb;
    while (!rsp_valid_out && cnt < 40) begin
      apb_ready_in = (cnt >= 2) && ((cnt - 1) > v.waits);
      @(posedge clk); #1;
      cnt++;
      if (!rsp_valid_out) begin
        check("access_psel", apb_psel_out, 1);
        check("access_penable", apb_penable_out, 1);
        check("access_addr", apb_addr_out, v.addr);
        check("access_write", apb_write_out, v.wr);
        check("access_wdata", apb_wdata_out, exp_wd);
        check("access_strb", apb_strb_out, exp_sb);
      end
    end
    cmd_valid_in = 1'b0;
    apb_ready_in = 1'b0;
    check("rsp_latency", cnt, v.lat);
    check("rsp_valid", rsp_valid_out, 1);
    check("rsp_rdata", rsp_rdata_out, v.exp_rdata);
    check("rsp_err", rsp_err_out, v.exp_err);
    check("rsp_timeout", rsp_timeout_out, v.exp_to);
    check("end_psel", apb_psel_out, 0);
    check("end_penable", apb_penable_out, 0);
    check("end_cmd_ready", cmd_ready_out, 1);
    @(posedge clk); #1;
    check("rsp_pulse_drop", rsp_valid_out, 0);
    check("rsp_err_hold", rsp_err_out, v.exp_err);
    check("rsp_timeout_hold", rsp_timeout_out, v.exp_to);
    check("rsp_rdata_hold", rsp_rdata_out, v.exp_rdata);
    check("idle_psel", apb_psel_out, 0);
  endtask

  vec_t vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2;
    logic saw_rsp;
    vec_t rv;

    rst           = 1'b1;
    cmd_valid_in  = 1'b0;
    cmd_write_in  = 1'b0;
    cmd_addr_in   = '0;
    cmd_wdata_in  = '0;
    cmd_strb_in   = '0;
    apb_rdata_in  = '0;
    apb_ready_in  = 1'b0;
    apb_slverr_in = 1'b0;
    #12;
    check("rst_cmd_ready", cmd_ready_out, 1);
    check("rst_psel", apb_psel_out, 0);
    check("rst_penable", apb_penable_out, 0);
    check("rst_write", apb_write_out, 0);
    check("rst_addr", apb_addr_out, 0);
    check("rst_wdata", apb_wdata_out, 0);
    check("rst_strb", apb_strb_out, 0);
    check("rst_rsp_valid", rsp_valid_out, 0);
    check("rst_rsp_rdata", rsp_rdata_out, 0);
    check("rst_rsp_err", rsp_err_out, 0);
    check("rst_rsp_timeout", rsp_timeout_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    vecs[0] = mk(1'b0, spi_reg_addr(SPI_SR),  32'h12345678, 4'hf,   0, 1'b0, 32'h00000004, 3, 32'h00000004, 1'b0, 1'b0);
    vecs[1] = mk(1'b1, spi_reg_addr(SPI_DR),  32'h0000005a, 4'h1,   2, 1'b0, 32'hffffffff, 5, 32'h0,        1'b0, 1'b0);
    vecs[2] = mk(1'b0, spi_reg_addr(SPI_CR1), 32'h0,        4'h0,   0, 1'b1, 32'hdeadbeef, 3, 32'h0,        1'b1, 1'b0);
    vecs[3] = mk(1'b0, spi_reg_addr(SPI_SR),  32'h0,        4'h0, 100, 1'b0, 32'h00001111, 8, 32'h0,        1'b1, 1'b1);
    vecs[4] = mk(1'b0, spi_reg_addr(SPI_SPR), 32'h0,        4'h0,   5, 1'b0, 32'h00000077, 8, 32'h00000077, 1'b0, 1'b0);
    vecs[5] = mk(1'b1, spi_reg_addr(SPI_CR2), 32'h0000a5a5, 4'h3,   1, 1'b1, 32'h00000055, 4, 32'h0,        1'b1, 1'b0);
    vecs[6] = mk(1'b1, spi_reg_addr(SPI_DR),  32'h0000cafe, 4'hf,   6, 1'b0, 32'h0,        8, 32'h0,        1'b1, 1'b1);
    vecs[7] = mk(1'b0, spi_reg_addr(SPI_SR),  32'h0,        4'h0,   6, 1'b1, 32'h00000099, 8, 32'h0,        1'b1, 1'b1);
    vecs[8] = mk(1'b0, spi_reg_addr(SPI_SR),  32'h0,        4'h0,   4, 1'b0, 32'h00000031, 7, 32'h00000031, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      run_xfer(vecs[i]);
    end

    // Reset asserted mid-ACCESS: bus drops asynchronously and no response follows
    cmd_valid_in = 1'b1;
    cmd_write_in = 1'b0;
    cmd_addr_in  = spi_reg_addr(SPI_SR);
    apb_ready_in = 1'b0;
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_penable", apb_penable_out, 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_psel", apb_psel_out, 0);
    check("async_rst_penable", apb_penable_out, 0);
    check("async_rst_cmd_ready", cmd_ready_out, 1);
    check("async_rst_rsp_valid", rsp_valid_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_rsp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_out || apb_psel_out) saw_rsp = 1'b1;
    end
    check("post_rst_no_rsp", saw_rsp, 0);
    check("post_rst_cmd_ready", cmd_ready_out, 1);
    run_xfer(mk(1'b0, spi_reg_addr(SPI_SR), 32'h0, 4'h0, 0, 1'b0, 32'h00000084, 3, 32'h00000084, 1'b0, 1'b0));

    // Back-to-back reads with cmd_valid held high
    cmd_valid_in  = 1'b1;
    cmd_write_in  = 1'b0;
    cmd_addr_in   = spi_reg_addr(SPI_SR);
    apb_ready_in  = 1'b1;
    apb_slverr_in = 1'b0;
    apb_rdata_in  = 32'h11110001;
    t = 0; t1 = -1; t2 = -1;
    while (t < 20 && t2 < 0) begin
      @(posedge clk); #1;
      t++;
      if (rsp_valid_out) begin
        if (t1 < 0) begin
          t1 = t;
          check("b2b_rdata1", rsp_rdata_out, 32'h11110001);
          check("b2b_ready_in_rsp", cmd_ready_out, 1);
          cmd_addr_in  = spi_reg_addr(SPI_DR);
          apb_rdata_in = 32'h22220002;
        end else begin
          t2 = t;
          check("b2b_rdata2", rsp_rdata_out, 32'h22220002);
        end
      end
      if (t1 > 0 && t == t1 + 1) begin
        check("b2b_accept_psel", apb_psel_out, 1);
        check("b2b_accept_addr", apb_addr_out, spi_reg_addr(SPI_DR));
        cmd_valid_in = 1'b0;
      end
    end
    apb_ready_in = 1'b0;
    cmd_valid_in = 1'b0;
    check("b2b_first_latency", t1, 3);
    check("b2b_spacing", t2 - t1, 3);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      rv = model($urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom),
                 $urandom_range(0, 8), $urandom_range(0, 3) == 0, $urandom);
      run_xfer(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
